// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and default bit timing.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  // 50 MHz system clock, 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx_core_if.sv
// Byte delivery interface from the UART receiver to its consumer (valid/ready plus error pulses).
interface uart_rx_core_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ready
  );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous input; both stages reset to INIT.
module uart_sync #(
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= INIT;
      sync_q <= INIT;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: mid-bit start validation, centre sampling of data and stop bits,
// byte handed off on a valid/ready interface with framing-error and overrun pulses.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_i,
  uart_rx_core_if.master    rx_if
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  uart_sync #(.INIT(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;

  logic bit_end;
  logic half_end;
  logic stop_end;

  assign bit_end  = (cnt_q == BIT_END);
  assign half_end = (cnt_q == HALF_END);
  assign stop_end = (state_q == STOP) && bit_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      armed_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      armed_q   <= armed_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    armed_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Only a falling edge after the line was seen high starts a frame; a held-low line never retriggers.
        armed_d = armed_q | rx_s;
        if (armed_q && !rx_s) begin
          state_d = START;
        end
      end
      START: begin
        if (half_end) begin
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;

    if (valid_q && rx_if.rx_ready) begin
      valid_d = 1'b0;
    end

    if (stop_end) begin
      if (!rx_s) begin
        fe_d = 1'b1;
      end else if (!valid_q || rx_if.rx_ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  assign rx_if.rx_data   = data_q;
  assign rx_if.rx_valid  = valid_q;
  assign rx_if.frame_err = fe_q;
  assign rx_if.overrun   = ov_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scenario bench for uart_rx_core at 16 clocks per bit; expected bytes flow through a scoreboard queue.
module tb_uart_rx_core;

  localparam int CPB     = 16;
  localparam int LATENCY = 3 + CPB / 2 + 9 * CPB;

  logic clk;
  logic rst_n;
  logic rx_i;

  uart_rx_core_if bus ();

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_i  (rx_i),
    .rx_if (bus)
  );

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) fe_cnt++;
    if (bus.overrun === 1'b1) ov_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_i = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int limit, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < limit) begin
      @(posedge clk);
      #2;
      cyc++;
      if (bus.rx_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_i = 1'b1;
    bus.rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.rx_valid); end
    checks++;
    if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.rx_data); end
    checks++;
    if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", bus.frame_err); end
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
    $display("reset: valid=%b data=%h", bus.rx_valid, bus.rx_data);
  endtask

  task automatic test_clean();
    int cyc;
    bit ok;
    int fe0, ov0;
    logic [7:0] exp;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      wait_valid(400, cyc, ok);
    join
    exp = exp_q.pop_front();
    checks++;
    if (!ok || cyc != LATENCY) begin errors++; $display("FAIL clean_latency got %0d want %0d", cyc, LATENCY); end
    checks++;
    if (bus.rx_data !== exp) begin errors++; $display("FAIL clean_data got %h want %h", bus.rx_data, exp); end
    checks++;
    if (fe_cnt != fe0) begin errors++; $display("FAIL clean_frame_err got %0d pulses want 0", fe_cnt - fe0); end
    checks++;
    if (ov_cnt != ov0) begin errors++; $display("FAIL clean_overrun got %0d pulses want 0", ov_cnt - ov0); end
    $display("clean: byte=%h latency=%0d", bus.rx_data, cyc);
  endtask

  task automatic test_glitch();
    int cyc;
    bit ok;
    int vseen;
    int fe0;
    logic [7:0] exp;
    fe0 = fe_cnt;
    vseen = 0;
    bus.rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rx_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_i = 1'b1;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(posedge clk);
      #2;
      if (bus.rx_valid === 1'b1) vseen++;
    end
    checks++;
    if (vseen != 0) begin errors++; $display("FAIL glitch_valid got %0d valid cycles want 0", vseen); end
    checks++;
    if (fe_cnt != fe0) begin errors++; $display("FAIL glitch_frame_err got %0d pulses want 0", fe_cnt - fe0); end
    exp_q.push_back(8'h3C);
    fork
      send_frame(8'h3C, 1'b1);
      wait_valid(400, cyc, ok);
    join
    exp = exp_q.pop_front();
    checks++;
    if (!ok || bus.rx_data !== exp) begin errors++; $display("FAIL glitch_next_data got %h want %h", bus.rx_data, exp); end
    $display("glitch: next byte=%h", bus.rx_data);
  endtask

  task automatic test_frame_err();
    int cyc;
    bit ok;
    int vseen;
    int fe0;
    logic [7:0] exp;
    fe0 = fe_cnt;
    vseen = 0;
    bus.rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send_frame(8'h55, 1'b0);
    for (int i = 0; i < 100 * CPB; i++) begin
      @(posedge clk);
      #2;
      if (bus.rx_valid === 1'b1) vseen++;
    end
    checks++;
    if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_pulses got %0d want 1", fe_cnt - fe0); end
    checks++;
    if (vseen != 0) begin errors++; $display("FAIL ferr_valid got %0d valid cycles want 0", vseen); end
    rx_i = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    exp_q.push_back(8'h0F);
    fork
      send_frame(8'h0F, 1'b1);
      wait_valid(400, cyc, ok);
    join
    exp = exp_q.pop_front();
    checks++;
    if (!ok || bus.rx_data !== exp) begin errors++; $display("FAIL ferr_next_data got %h want %h", bus.rx_data, exp); end
    $display("frame_err: pulses=%0d next byte=%h", fe_cnt - fe0, bus.rx_data);
  endtask

  task automatic test_back_to_back();
    int ov0;
    logic [7:0] exp;
    repeat (4) @(posedge clk);
    #1;
    bus.rx_ready = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", bus.rx_valid); end
    checks++;
    if (bus.rx_data !== exp) begin errors++; $display("FAIL b2b_data got %h want %h", bus.rx_data, exp); end
    checks++;
    if (ov_cnt - ov0 != 1) begin errors++; $display("FAIL b2b_overrun got %0d pulses want 1", ov_cnt - ov0); end
    @(posedge clk);
    #1;
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop got %b want 0", bus.rx_valid); end
    bus.rx_ready = 1'b0;
    $display("back_to_back: byte=%h overruns=%0d", exp, ov_cnt - ov0);
  endtask

  task automatic test_ready_on_delivery();
    int ov0;
    logic [7:0] exp;
    repeat (4) @(posedge clk);
    #1;
    bus.rx_ready = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1);
    exp = exp_q.pop_front();
    checks++;
    if (bus.rx_valid !== 1'b1 || bus.rx_data !== exp) begin errors++; $display("FAIL rod_first got %b/%h want 1/%h", bus.rx_valid, bus.rx_data, exp); end
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (LATENCY - 1) @(posedge clk);
        #1;
        bus.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_ready = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (bus.rx_data !== exp) begin errors++; $display("FAIL rod_data got %h want %h", bus.rx_data, exp); end
        checks++;
        if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL rod_valid got %b want 1", bus.rx_valid); end
      end
    join
    checks++;
    if (ov_cnt != ov0) begin errors++; $display("FAIL rod_overrun got %0d pulses want 0", ov_cnt - ov0); end
    $display("ready_on_delivery: byte=%h overruns=%0d", bus.rx_data, ov_cnt - ov0);
  endtask

  task automatic test_mid_reset();
    int cyc;
    bit ok;
    logic [7:0] exp;
    bus.rx_ready = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL mrst_pre_valid got %b want 1", bus.rx_valid); end
    fork
      send_frame(8'h96, 1'b1);
      begin
        repeat (5 * CPB) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %b want 0", bus.rx_valid); end
        checks++;
        if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL mrst_data got %h want 00", bus.rx_data); end
      end
    join
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.rx_ready = 1'b1;
    exp_q.push_back(8'hFF);
    fork
      send_frame(8'hFF, 1'b1);
      wait_valid(400, cyc, ok);
    join
    exp = exp_q.pop_front();
    checks++;
    if (!ok || bus.rx_data !== exp) begin errors++; $display("FAIL mrst_next_data got %h want %h", bus.rx_data, exp); end
    $display("mid_reset: next byte=%h", bus.rx_data);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_i = 1'b1;
    bus.rx_ready = 1'b0;
    test_reset();
    test_clean();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_ready_on_delivery();
    test_mid_reset();
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
8N1 UART receiver running on the system clock. Bit timing comes from an internal divide-by-CLKS_PER_BIT counter, so no derived clock is needed. It resynchronises the serial line, validates the start bit at mid-bit, and samples each data bit and the stop bit at its centre. The received byte is presented on a valid/ready interface to the command parser, with framing and overrun flags.

Parameters:
CLKS_PER_BIT, 434, system clocks per bit (50 MHz / 115200); legal range 8..65535
HALF_BIT, CLKS_PER_BIT/2, start-bit validation point (derived; not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
rx_i  input  1  asynchronous serial line, idle high
rx_data  output  8  received byte, LSB first on the wire
rx_valid  output  1  rx_data holds an unconsumed byte
rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: byte completed while previous byte still unconsumed

Behaviour:
- Reset (async assert, sync release):
  - synchroniser flops = 1
  - state = IDLE, counters = 0, armed = 0
  - rx_data = 0x00; rx_valid, frame_err, overrun = 0
- Synchroniser: 2-FF on rx_i; all decisions use the 2nd stage (rx_s). Pin-to-rx_s latency is 2 cycles.
- armed flag:
  - set when rx_s = 1 in IDLE
  - cleared on leaving IDLE
  - a line held low (break, or low after a framing error) never retriggers
- Bit counter cnt:
  - cleared on every state entry, increments each cycle
  - a bit ends when cnt == CLKS_PER_BIT-1; START ends when cnt == HALF_BIT-1
- State machine:
  - IDLE: armed && rx_s == 0 -> START.
  - START: at cnt == HALF_BIT-1, rx_s == 0 -> DATA (bit_idx = 0); rx_s == 1 -> IDLE (glitch, no flag).
  - DATA: at end of bit, shift rx_s into shreg MSB (right shift, LSB first); bit_idx == 7 -> STOP, else bit_idx++.
  - STOP: at end of bit, go to IDLE.
    - rx_s == 1: byte delivered per the handshake rules.
    - rx_s == 0: frame_err pulses for 1 cycle; byte discarded; rx_valid and rx_data unchanged.
- Handshake, evaluated on the delivery cycle:
  - rx_valid == 0, or rx_ready == 1: rx_data <= shreg, rx_valid <= 1, no overrun.
  - rx_valid == 1 && rx_ready == 0: old byte kept, new byte dropped, overrun pulses 1 cycle.
  - Otherwise rx_valid clears the cycle after rx_valid && rx_ready.
  - rx_data is stable while rx_valid == 1.
- Latency: rx_valid rises exactly 3 + HALF_BIT + 9*CLKS_PER_BIT cycles after rx_i falls for the start bit, given a clean frame and an idle output.
- Mid-frame reset: returns to IDLE and clears outputs. The partial byte is lost. armed = 0, so reception resumes only after the line has been seen high.
- Frame spacing: back-to-back frames with zero idle time are received; the stop bit re-arms IDLE.

Decomposition:
- Package uart_pkg holds:
  - state enum: IDLE, START, DATA, STOP
  - DATA_BITS = 8
  - default CLKS_PER_BIT for 50 MHz / 115200
- Sub-module uart_sync: 2-FF synchroniser with reset value parameter INIT = 1. It is shared with future UART blocks.

Test Plan:
- All tests use CLKS_PER_BIT = 16.
- Clean byte 0xA5, rx_ready = 1: rx_valid pulses at cycle 3+8+144 = 155 after start edge; rx_data = 0xA5; no flags.
- 4-cycle low glitch on idle line: no state change beyond START; rx_valid, frame_err = 0; next frame 0x3C received correctly.
- Frame 0x55 with stop bit driven low, line then held low for 100 bits: frame_err single pulse; rx_valid stays 0; no further frames until line goes high; then 0x0F received.
- Two back-to-back frames 0x11, 0x22 with rx_ready = 0: rx_data = 0x11, rx_valid = 1, overrun pulses once at the second delivery. Raise rx_ready: rx_valid drops the next cycle.
- rx_ready asserted on the exact delivery cycle of the second frame: rx_data = 0x22, rx_valid stays 1, overrun = 0.
- rst_n asserted during DATA bit 4: outputs = 0 immediately. After release with line high, frame 0xFF is received correctly.
